// File: rtl/main_alu_core_pkg.sv
// Shared types and widths for the main_alu_core slice.
// Optional divider is controlled by MAIN_ALU_DIV_EN in main_alu_core.sv.
package main_alu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RES_W   = 64;
    localparam int unsigned SHAMT_W = 6;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_DIV = 3'b011,
        OP_SHL = 3'b100,
        OP_SHR = 3'b101,
        OP_ROL = 3'b110,
        OP_ROR = 3'b111
    } alu_op_e;

endpackage

// File: rtl/main_alu_core_if.sv
// Operand/opcode bus into the ALU and registered result/flag back out.
interface main_alu_core_if;
    import main_alu_pkg::*;

    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [2:0]         opcode;
    logic [SHAMT_W-1:0] shift;
    logic [RES_W-1:0]   out;
    logic               carry;

    modport master (output a, b, opcode, shift, input  out, carry);
    modport slave  (input  a, b, opcode, shift, output out, carry);
endinterface

// File: rtl/main_alu_core_shifter.sv
// 64-bit barrel shifter/rotator for SHL/SHR/ROL/ROR, with the last shifted-out bit.
module barrel_shifter64
    import main_alu_pkg::*;
(
    input  logic [RES_W-1:0]   w,
    input  logic [SHAMT_W-1:0] shamt,
    input  alu_op_e            op,
    output logic [RES_W-1:0]   res,
    output logic               shout
);

    // 64 - shamt modulo 64; equals 0 when shamt is 0, so rotates degrade to w|w.
    logic [SHAMT_W-1:0] neg_sh;
    logic               nz;

    assign neg_sh = SHAMT_W'(0) - shamt;
    assign nz     = |shamt;

    always_comb begin
        res   = w;
        shout = 1'b0;
        case (op)
            OP_SHL: begin
                res   = w << shamt;
                shout = nz & w[neg_sh];
            end
            OP_SHR: begin
                res   = w >> shamt;
                shout = nz & w[shamt - SHAMT_W'(1)];
            end
            OP_ROL: res = (w << shamt) | (w >> neg_sh);
            OP_ROR: res = (w >> shamt) | (w << neg_sh);
            default: begin
                res   = w;
                shout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/main_alu_core.sv
// Registered 32-bit ALU with 64-bit result and carry/status flag.
// Define MAIN_ALU_DIV_EN to build the single-cycle divider for opcode 011.
module main_alu_core
    import main_alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    main_alu_core_if.slave  bus
);

    alu_op_e            op;
    logic [RES_W-1:0]   w;
    logic [RES_W-1:0]   sh_res;
    logic               sh_out;
    logic [DATA_W:0]    sum;
    logic [DATA_W:0]    diff;
    logic [RES_W-1:0]   prod;
    logic [RES_W-1:0]   res_d;
    logic               carry_d;

    assign op   = alu_op_e'(bus.opcode);
    assign w    = {bus.b, bus.a};
    assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff = {1'b0, bus.a} - {1'b0, bus.b};
    assign prod = {{DATA_W{1'b0}}, bus.a} * {{DATA_W{1'b0}}, bus.b};

    barrel_shifter64 u_shifter (
        .w     (w),
        .shamt (bus.shift),
        .op    (op),
        .res   (sh_res),
        .shout (sh_out)
    );

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        unique case (op)
            OP_ADD: begin
                res_d   = {{DATA_W{1'b0}}, sum[DATA_W-1:0]};
                carry_d = sum[DATA_W];
            end
            OP_SUB: begin
                res_d   = {{DATA_W{1'b0}}, diff[DATA_W-1:0]};
                carry_d = diff[DATA_W];
            end
            OP_MUL: res_d = prod;
            OP_DIV: begin
`ifdef MAIN_ALU_DIV_EN
                if (bus.b == '0) begin
                    res_d   = {bus.a, {DATA_W{1'b1}}};
                    carry_d = 1'b1;
                end else begin
                    res_d   = {bus.a % bus.b, bus.a / bus.b};
                    carry_d = 1'b0;
                end
`else
                res_d   = '0;
                carry_d = 1'b1;
`endif
            end
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
                res_d   = sh_res;
                carry_d = sh_out;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out   <= '0;
            bus.carry <= 1'b0;
        end else begin
            bus.out   <= res_d;
            bus.carry <= carry_d;
        end
    end

endmodule

// File: tb/tb_main_alu_core.sv
// Directed-vector bench for main_alu_core; DIV vectors follow MAIN_ALU_DIV_EN.
module tb_main_alu_core;
    import main_alu_pkg::*;

    logic clk;
    logic rst;
    int unsigned n_pass;
    int unsigned n_total;

    main_alu_core_if bus ();

    main_alu_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drive inputs away from the edge, then sample 1 time unit after the capturing edge.
    task automatic run(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] sh, input logic r);
        @(negedge clk);
        bus.opcode = op;
        bus.a      = a;
        bus.b      = b;
        bus.shift  = sh;
        rst        = r;
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input string tag, input alu_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] sh,
                       input logic [63:0] exp_out, input logic exp_c);
        run(op, a, b, sh, 1'b0);
        check({tag, ".out"}, bus.out, exp_out);
        check({tag, ".carry"}, {63'd0, bus.carry}, {63'd0, exp_c});
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        bus.a = '0; bus.b = '0; bus.opcode = '0; bus.shift = '0;

        for (int i = 0; i < 2; i++) begin
            run(OP_ADD, 32'd23, 32'd12, 6'd0, 1'b1);
            check("rst.out", bus.out, 64'd0);
            check("rst.carry", {63'd0, bus.carry}, 64'd0);
        end

        vec("add",      OP_ADD, 32'd23, 32'd12, 6'd0, 64'd35, 1'b0);
        vec("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 6'd0, 64'd0, 1'b1);
        vec("sub",      OP_SUB, 32'd50, 32'd20, 6'd0, 64'd30, 1'b0);
        vec("sub_brw",  OP_SUB, 32'd10, 32'd25, 6'd0, 64'h0000_0000_FFFF_FFF1, 1'b1);
        vec("sub_eq",   OP_SUB, 32'd7, 32'd7, 6'd0, 64'd0, 1'b0);
        vec("mul",      OP_MUL, 32'd7, 32'd6, 6'd0, 64'd42, 1'b0);
        vec("mul2",     OP_MUL, 32'd1000, 32'd6, 6'd0, 64'd6000, 1'b0);
        vec("mul_max",  OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd0, 64'hFFFF_FFFE_0000_0001, 1'b0);
`ifdef MAIN_ALU_DIV_EN
        vec("div",      OP_DIV, 32'd100, 32'd10, 6'd0, 64'h0000_0000_0000_000A, 1'b0);
        vec("div_rem",  OP_DIV, 32'd103, 32'd10, 6'd0, 64'h0000_0003_0000_000A, 1'b0);
        vec("div_zero", OP_DIV, 32'd5, 32'd0, 6'd0, 64'h0000_0005_FFFF_FFFF, 1'b1);
`else
        vec("div_off",  OP_DIV, 32'd103, 32'd10, 6'd0, 64'd0, 1'b1);
`endif
        vec("shl",      OP_SHL, 32'hAAAA_AAAA, 32'h5555_5555, 6'd4, 64'h5555_555A_AAAA_AAA0, 1'b1);
        vec("shr",      OP_SHR, 32'hAAAA_AAAA, 32'h5555_5555, 6'd4, 64'h0555_5555_5AAA_AAAA, 1'b1);
        vec("shl63",    OP_SHL, 32'd3, 32'd0, 6'd63, 64'h8000_0000_0000_0000, 1'b1);
        vec("shr63",    OP_SHR, 32'd0, 32'hC000_0000, 6'd63, 64'd1, 1'b1);
        vec("shl0",     OP_SHL, 32'h1234_5678, 32'h8765_4321, 6'd0, 64'h8765_4321_1234_5678, 1'b0);
        vec("shr0",     OP_SHR, 32'h1234_5679, 32'h8765_4321, 6'd0, 64'h8765_4321_1234_5679, 1'b0);
        vec("rol",      OP_ROL, 32'h1234_5678, 32'h8765_4321, 6'd8, 64'h6543_2112_3456_7887, 1'b0);
        vec("ror",      OP_ROR, 32'h1234_5678, 32'h8765_4321, 6'd8, 64'h7887_6543_2112_3456, 1'b0);
        vec("rol0",     OP_ROL, 32'h1234_5678, 32'h8765_4321, 6'd0, 64'h8765_4321_1234_5678, 1'b0);
        vec("ror0",     OP_ROR, 32'h1234_5678, 32'h8765_4321, 6'd0, 64'h8765_4321_1234_5678, 1'b0);

        // Reset mid-stream wins over a pending operation, then the next edge resumes.
        run(OP_ADD, 32'hFFFF_FFFF, 32'd1, 6'd0, 1'b1);
        check("midrst.out", bus.out, 64'd0);
        check("midrst.carry", {63'd0, bus.carry}, 64'd0);
        vec("post_rst", OP_ADD, 32'd1, 32'd2, 6'd0, 64'd3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
